// File: rtl/hazard_scoreboard_ctrl.sv
// Pipeline hazard/stall controller: pending-count scoreboard, RAW and saturation issue gating,
// memory-wait FSM with sticky watchdog. Optional macro HAZARD_SB_WB_BYPASS_EN: same-cycle final retire clears RAW.
module hazard_scoreboard_ctrl #(
  parameter int NUM_REGS    = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int PEND_W      = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int TMO_W       = 7
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic                  id_rs1_used_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_rd_we_i,
  input  logic                  ex_branch_taken_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ready_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_rd_we_i,
  output logic                  issue_o,
  output logic                  if_stall_o,
  output logic                  id_stall_o,
  output logic                  ex_stall_o,
  output logic                  mem_stall_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_bubble_o,
  output logic                  mem_wb_bubble_o,
  output logic [1:0]            state_o,
  output logic                  busy_o,
  output logic                  mem_timeout_o,
  output logic                  sb_error_o
);

  localparam int                ADDR_N      = 2**REG_ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX    = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE    = PEND_W'(1);
  localparam logic [1:0]        ST_RUN      = 2'd0;
  localparam logic [1:0]        ST_MEM_WAIT = 2'd1;
  localparam logic [TMO_W-1:0]  TMO_LIMIT   = TMO_W'(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_ONE     = TMO_W'(1);

  logic [PEND_W-1:0] pend_q [ADDR_N];
  logic [PEND_W-1:0] pend_d [ADDR_N];
  logic [1:0]        state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic              sb_error_q, sb_error_d;

  logic [PEND_W-1:0] pend_rs1, pend_rs2, pend_rd, pend_wb;
  logic              rs1_hz, rs2_hz, raw, sat, mem_hold;
  logic              inc, dec, dec_err, busy;
  logic              issue, if_stall, id_stall, ex_stall, mem_stall;
  logic              if_id_flush, id_ex_bubble, mem_wb_bubble;

  assign pend_rs1 = pend_q[id_rs1_i];
  assign pend_rs2 = pend_q[id_rs2_i];
  assign pend_rd  = pend_q[id_rd_i];
  assign pend_wb  = pend_q[wb_rd_i];

  assign inc = issue && id_rd_we_i && (id_rd_i != '0);
  assign dec = wb_valid_i && wb_rd_we_i && (wb_rd_i != '0);

`ifdef HAZARD_SB_WB_BYPASS_EN
  // A retire that empties the counter this cycle is visible through the write-through register file.
  assign rs1_hz = id_rs1_used_i && (id_rs1_i != '0) && (pend_rs1 != '0)
                  && !(dec && (wb_rd_i == id_rs1_i) && (pend_rs1 == PEND_ONE));
  assign rs2_hz = id_rs2_used_i && (id_rs2_i != '0) && (pend_rs2 != '0)
                  && !(dec && (wb_rd_i == id_rs2_i) && (pend_rs2 == PEND_ONE));
`else
  assign rs1_hz = id_rs1_used_i && (id_rs1_i != '0) && (pend_rs1 != '0);
  assign rs2_hz = id_rs2_used_i && (id_rs2_i != '0) && (pend_rs2 != '0);
`endif

  assign raw      = rs1_hz || rs2_hz;
  assign sat      = id_rd_we_i && (id_rd_i != '0) && (pend_rd == PEND_MAX);
  assign mem_hold = ((state_q == ST_RUN) && mem_req_i && !mem_ready_i)
                    || ((state_q == ST_MEM_WAIT) && !mem_ready_i);

  // A simultaneous issue to the same register keeps a zero count legal.
  assign dec_err = dec && (pend_wb == '0) && !(inc && (id_rd_i == wb_rd_i));

  for (genvar gi = 0; gi < ADDR_N; gi++) begin : g_pend
    if (gi == 0 || gi >= NUM_REGS) begin : g_untracked
      assign pend_d[gi] = '0;
    end else begin : g_tracked
      logic inc_hit, dec_hit;
      assign inc_hit = inc && (id_rd_i == REG_ADDR_W'(gi));
      assign dec_hit = dec && (wb_rd_i == REG_ADDR_W'(gi));
      assign pend_d[gi] = (inc_hit && !dec_hit) ? pend_q[gi] + PEND_ONE
                        : (dec_hit && !inc_hit && pend_q[gi] != '0) ? pend_q[gi] - PEND_ONE
                        : pend_q[gi];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < ADDR_N; i++) begin
      if (pend_q[i] != '0) busy = 1'b1;
    end
  end

  // State register process.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < ADDR_N; i++) pend_q[i] <= '0;
      state_q       <= ST_RUN;
      tmo_q         <= '0;
      mem_timeout_q <= 1'b0;
      sb_error_q    <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      mem_timeout_q <= mem_timeout_d;
      sb_error_q    <= sb_error_d;
    end
  end

  // Next-state process.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_RUN: begin
        tmo_d = '0;
        if (mem_req_i && !mem_ready_i) begin
          state_d = ST_MEM_WAIT;
          tmo_d   = TMO_ONE;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready_i) begin
          state_d = ST_RUN;
          tmo_d   = '0;
        end else if (tmo_q != TMO_LIMIT) begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
        tmo_d   = '0;
      end
    endcase
    mem_timeout_d = mem_timeout_q || ((state_d == ST_MEM_WAIT) && (tmo_d == TMO_LIMIT));
    sb_error_d    = sb_error_q || dec_err;
  end

  // Output process: memory hold outranks branch flush, which outranks hazard stall.
  always_comb begin
    issue         = 1'b0;
    if_stall      = 1'b0;
    id_stall      = 1'b0;
    ex_stall      = 1'b0;
    mem_stall     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (mem_hold) begin
      if_stall      = 1'b1;
      id_stall      = 1'b1;
      ex_stall      = 1'b1;
      mem_stall     = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken_i) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (id_valid_i && (raw || sat)) begin
      if_stall     = 1'b1;
      id_stall     = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      issue = id_valid_i;
    end
  end

  assign issue_o         = !reset_i && issue;
  assign if_stall_o      = !reset_i && if_stall;
  assign id_stall_o      = !reset_i && id_stall;
  assign ex_stall_o      = !reset_i && ex_stall;
  assign mem_stall_o     = !reset_i && mem_stall;
  assign if_id_flush_o   = !reset_i && if_id_flush;
  assign id_ex_bubble_o  = !reset_i && id_ex_bubble;
  assign mem_wb_bubble_o = !reset_i && mem_wb_bubble;
  assign state_o         = reset_i ? ST_RUN : state_q;
  assign busy_o          = !reset_i && busy;
  assign mem_timeout_o   = !reset_i && mem_timeout_q;
  assign sb_error_o      = !reset_i && sb_error_q;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed self-checking bench for hazard_scoreboard_ctrl; expected stall count depends on HAZARD_SB_WB_BYPASS_EN.
module tb_hazard_scoreboard_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       id_valid_i, id_rs1_used_i, id_rs2_used_i, id_rd_we_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i, wb_rd_i;
  logic       ex_branch_taken_i, mem_req_i, mem_ready_i, wb_valid_i, wb_rd_we_i;
  logic       issue_o, if_stall_o, id_stall_o, ex_stall_o, mem_stall_o;
  logic       if_id_flush_o, id_ex_bubble_o, mem_wb_bubble_o;
  logic [1:0] state_o;
  logic       busy_o, mem_timeout_o, sb_error_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int stalls;
  logic issued;

`ifdef HAZARD_SB_WB_BYPASS_EN
  localparam int EXP_RAW_STALLS = 2;
`else
  localparam int EXP_RAW_STALLS = 3;
`endif

  hazard_scoreboard_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs1_used_i(id_rs1_used_i),
    .id_rs2_i(id_rs2_i), .id_rs2_used_i(id_rs2_used_i), .id_rd_i(id_rd_i), .id_rd_we_i(id_rd_we_i),
    .ex_branch_taken_i(ex_branch_taken_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_rd_we_i(wb_rd_we_i),
    .issue_o(issue_o), .if_stall_o(if_stall_o), .id_stall_o(id_stall_o), .ex_stall_o(ex_stall_o),
    .mem_stall_o(mem_stall_o), .if_id_flush_o(if_id_flush_o), .id_ex_bubble_o(id_ex_bubble_o),
    .mem_wb_bubble_o(mem_wb_bubble_o), .state_o(state_o), .busy_o(busy_o),
    .mem_timeout_o(mem_timeout_o), .sb_error_o(sb_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    id_valid_i = 0; id_rs1_i = 0; id_rs1_used_i = 0; id_rs2_i = 0; id_rs2_used_i = 0;
    id_rd_i = 0; id_rd_we_i = 0; ex_branch_taken_i = 0; mem_req_i = 0; mem_ready_i = 0;
    wb_valid_i = 0; wb_rd_i = 0; wb_rd_we_i = 0;
  endtask

  task automatic retire(input logic [4:0] rd);
    wb_valid_i = 1; wb_rd_i = rd; wb_rd_we_i = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset: outputs forced low even with active requests
    reset_i = 1; idle(); id_valid_i = 1; mem_req_i = 1;
    #3;
    check("rst_issue", issue_o, 0);
    check("rst_if_stall", if_stall_o, 0);
    check("rst_state", state_o, 0);
    tick();
    check("rst_busy", busy_o, 0);
    check("rst_mem_stall", mem_stall_o, 0);
    #2 reset_i = 0; idle();
    tick();

    // T1: ADDI x5 then dependent ADD x6,x5,x1
    id_valid_i = 1; id_rd_i = 5; id_rd_we_i = 1; #1;
    check("t1_addi_issue", issue_o, 1);
    tick();
    id_rs1_i = 5; id_rs1_used_i = 1; id_rs2_i = 1; id_rs2_used_i = 1; id_rd_i = 6; #1;
    check("t1_add_bubble", id_ex_bubble_o, 1);
    check("t1_add_if_stall", if_stall_o, 1);
    check("t1_busy", busy_o, 1);
    stalls = 0; issued = 0;
    for (int k = 0; k < 10 && !issued; k++) begin
      wb_valid_i = (k == 2); wb_rd_i = 5; wb_rd_we_i = (k == 2); #1;
      if (issue_o) issued = 1;
      else begin stalls++; tick(); end
    end
    check("t1_add_issued", 32'(issued), 1);
    check("t1_stall_cycles", stalls, EXP_RAW_STALLS);
    tick(); idle(); retire(6);
    tick(); idle(); #1;
    check("t1_busy_clear", busy_o, 0);

    // T2: four writers of x7 saturate the 2-bit counter
    id_valid_i = 1; id_rd_i = 7; id_rd_we_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t2_issue%0d", i), issue_o, 32'(i < 3));
      if (i == 3) begin
        check("t2_sat_if_stall", if_stall_o, 1);
        check("t2_sat_bubble", id_ex_bubble_o, 1);
      end
      tick();
    end
    retire(7); #1;
    check("t2_sat_during_retire", issue_o, 0);
    tick(); wb_valid_i = 0; wb_rd_we_i = 0; #1;
    check("t2_issue_after_retire", issue_o, 1);
    tick(); #1;
    check("t2_sat_again", issue_o, 0);
    idle(); retire(7);
    tick(); tick(); tick(); idle(); #1;
    check("t2_busy_clear", busy_o, 0);

    // T3: five-cycle memory wait with a branch pulse inside it
    id_valid_i = 1; mem_req_i = 1; #1;
    check("t3_c0_state", state_o, 0);
    check("t3_c0_if_stall", if_stall_o, 1);
    check("t3_c0_mem_stall", mem_stall_o, 1);
    check("t3_c0_mwb_bubble", mem_wb_bubble_o, 1);
    check("t3_c0_issue", issue_o, 0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      ex_branch_taken_i = (c == 2); #1;
      check($sformatf("t3_c%0d_state", c), state_o, 1);
      check($sformatf("t3_c%0d_ex_stall", c), ex_stall_o, 1);
      check($sformatf("t3_c%0d_mwb_bubble", c), mem_wb_bubble_o, 1);
      if (c == 2) begin
        check("t3_branch_no_flush", if_id_flush_o, 0);
        check("t3_branch_no_bubble", id_ex_bubble_o, 0);
      end
      tick();
    end
    ex_branch_taken_i = 0; mem_ready_i = 1; #1;
    check("t3_ready_state", state_o, 1);
    check("t3_ready_no_stall", mem_stall_o, 0);
    check("t3_ready_issue", issue_o, 1);
    tick(); idle(); #1;
    check("t3_back_run", state_o, 0);

    // T4: watchdog after MEM_TIMEOUT wait cycles, then asynchronous reset mid-wait
    mem_req_i = 1;
    tick();
    for (int w = 1; w <= 64; w++) begin
      #1;
      if (w == 63) check("t4_no_timeout_63", mem_timeout_o, 0);
      if (w == 64) begin
        check("t4_timeout_64", mem_timeout_o, 1);
        check("t4_state_wait", state_o, 1);
      end
      if (w < 64) tick();
    end
    mem_req_i = 0; mem_ready_i = 1; #1;
    check("t4_timeout_at_ready", mem_timeout_o, 1);
    tick(); mem_ready_i = 0; #1;
    check("t4_run_after_ready", state_o, 0);
    check("t4_timeout_sticky", mem_timeout_o, 1);
    mem_req_i = 1;
    tick(); mem_req_i = 0; #1;
    check("t4_rewait_state", state_o, 1);
    #2 reset_i = 1;
    #1;
    check("t4_rst_state", state_o, 0);
    check("t4_rst_timeout", mem_timeout_o, 0);
    #1 reset_i = 0;
    #1;
    check("t4_post_rst_state", state_o, 0);
    check("t4_post_rst_timeout", mem_timeout_o, 0);
    check("t4_post_rst_mem_stall", mem_stall_o, 0);
    tick(); idle();

    // T5: branch flush outranks a RAW stall and issues nothing
    id_valid_i = 1; id_rd_i = 4; id_rd_we_i = 1; #1;
    check("t5_x4_issue", issue_o, 1);
    tick();
    id_rs1_i = 4; id_rs1_used_i = 1; id_rd_i = 8; ex_branch_taken_i = 1; #1;
    check("t5_flush", if_id_flush_o, 1);
    check("t5_bubble", id_ex_bubble_o, 1);
    check("t5_issue", issue_o, 0);
    check("t5_if_stall", if_stall_o, 0);
    tick(); idle(); retire(4);
    tick(); idle(); #1;
    check("t5_busy_clear", busy_o, 0);

    // T6: retire underflow, x0 untracked, same-cycle inc/dec
    check("t6_sb_error_before", sb_error_o, 0);
    retire(3);
    tick(); idle(); #1;
    check("t6_sb_error_set", sb_error_o, 1);
    check("t6_busy_after_underflow", busy_o, 0);
    id_valid_i = 1; id_rd_i = 0; id_rd_we_i = 1; #1;
    check("t6_x0_issue", issue_o, 1);
    tick(); idle(); #1;
    check("t6_x0_untracked", busy_o, 0);
    id_valid_i = 1; id_rd_i = 9; id_rd_we_i = 1;
    tick();
    retire(9); #1;
    check("t6_x9_issue_with_retire", issue_o, 1);
    tick(); idle(); #1;
    check("t6_x9_still_pending", busy_o, 1);
    check("t6_sb_error_sticky", sb_error_o, 1);
    retire(9);
    tick(); idle(); #1;
    check("t6_x9_cleared", busy_o, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_ctrl.md
Name: hazard_scoreboard_ctrl

Overview:
- Sequential hazard and stall controller for the 5-stage pipeline.
- Sits beside the per-stage control decode.
- Tracks in-flight register writes in a per-register pending-count scoreboard and gates ID→EX issue on RAW hazards and pending-count saturation.
- Runs a memory-wait FSM with a timeout watchdog; produces per-stage stall, flush and bubble controls, including branch-taken flush.

Parameters:
NUM_REGS, 32, architectural register count; register 0 is never tracked.
REG_ADDR_W, 5, register index width; must satisfy 2**REG_ADDR_W >= NUM_REGS.
PEND_W, 2, pending-counter width per register; PEND_MAX = 2**PEND_W-1.
MEM_TIMEOUT, 64, maximum cycles spent in MEM_WAIT before mem_timeout_o sets; must be at least 1.
TMO_W, 7, timeout counter width; must satisfy 2**TMO_W > MEM_TIMEOUT.

Ports:
clk_i  in  1  clock; all state updates on the rising edge
reset_i  in  1  asynchronous, active-high reset
id_valid_i  in  1  valid instruction in IF/ID
id_rs1_i  in  REG_ADDR_W  rs1 index of the ID instruction
id_rs1_used_i  in  1  ID instruction reads rs1
id_rs2_i  in  REG_ADDR_W  rs2 index of the ID instruction
id_rs2_used_i  in  1  ID instruction reads rs2
id_rd_i  in  REG_ADDR_W  rd index of the ID instruction
id_rd_we_i  in  1  ID instruction writes rd
ex_branch_taken_i  in  1  branch or jump resolved taken in EX
mem_req_i  in  1  MEM-stage instruction is a load or store
mem_ready_i  in  1  dmem completes the access this cycle
wb_valid_i  in  1  valid instruction in WB
wb_rd_i  in  REG_ADDR_W  WB destination index
wb_rd_we_i  in  1  WB writes the register file
issue_o  out  1  ID instruction advances into EX this cycle
if_stall_o  out  1  hold PC and IF/ID
id_stall_o  out  1  hold IF/ID contents
ex_stall_o  out  1  hold ID/EX
mem_stall_o  out  1  hold EX/MEM
if_id_flush_o  out  1  clear IF/ID valid
id_ex_bubble_o  out  1  load a NOP into ID/EX
mem_wb_bubble_o  out  1  load a NOP into MEM/WB
state_o  out  2  FSM state: 0 = RUN, 1 = MEM_WAIT
busy_o  out  1  any pending counter is nonzero
mem_timeout_o  out  1  sticky watchdog error
sb_error_o  out  1  sticky error: retire seen with pending count 0

Behaviour:
- Reset (asynchronous): all pending counters = 0, state = RUN, timeout counter = 0, both sticky errors = 0.
- While reset_i is high, every output is forced to 0.
- Hazard terms (combinational):
  - rs_hz(r) = used & r != 0 & pend[r] != 0.
  - raw = rs_hz(rs1) | rs_hz(rs2).
  - sat = id_rd_we_i & id_rd_i != 0 & pend[id_rd_i] == PEND_MAX.
- mem_hold = (state == RUN & mem_req_i & !mem_ready_i) | (state == MEM_WAIT & !mem_ready_i).
- Output priority, highest first:
  - mem_hold: if/id/ex/mem stall = 1 and mem_wb_bubble = 1. Branch and hazard outputs are suppressed; the branch stays in EX and reasserts later.
  - ex_branch_taken_i: if_id_flush = 1, id_ex_bubble = 1, issue_o = 0.
  - id_valid_i & (raw | sat): if_stall = 1, id_stall = 1, id_ex_bubble = 1.
  - Otherwise: issue_o = id_valid_i.
- Latency: a hazard clears in the cycle after the retiring WB edge. There is no forwarding; the decision is zero-cycle combinational.
- Scoreboard update on each edge:
  - inc = issue_o & id_rd_we_i & id_rd_i != 0.
  - dec = wb_valid_i & wb_rd_we_i & wb_rd_i != 0.
  - inc and dec on the same register: count unchanged.
  - dec with pend == 0: count stays 0 and sb_error_o sets.
  - A counter never exceeds PEND_MAX; the sat stall guarantees this.
- WB retire continues during mem_hold, because the MEM/WB bubble does not stop the instruction already in WB.
- FSM:
  - RUN → MEM_WAIT when mem_req_i & !mem_ready_i; the timeout counter loads 1.
  - MEM_WAIT → RUN when mem_ready_i; that cycle is not a stall.
  - In MEM_WAIT the timeout counter increments and saturates.
  - When the count reaches MEM_TIMEOUT, mem_timeout_o sets. It is sticky until reset; the FSM keeps waiting.
- Reset asserted mid-MEM_WAIT returns the FSM to RUN immediately and clears the scoreboard.

Optional Feature:
- Macro: HAZARD_SB_WB_BYPASS_EN.
- Defined: a register whose same-cycle dec drops pend from 1 to 0 is not a hazard that cycle. This matches a write-through register file and saves one stall cycle.
- Not defined: the hazard holds until the counter is 0 after the edge.

Test Plan:
1. ADDI x5 issues, then a dependent ADD x6,x5,x1 in ID → ADD stalls with id_ex_bubble = 1 until the cycle after WB of x5. Stall counts: 3 cycles without the bypass macro, 2 with it.
2. Four back-to-back issues writing x7 with PEND_W = 2, no retires → the 4th stalls with sat = 1 and pend[x7] = 3. After one WB retire of x7 it issues; pend returns to 3.
3. mem_req_i = 1 with mem_ready_i low for 5 cycles → state_o = 1 for 5 cycles; if/id/ex/mem stall and mem_wb_bubble are 1 throughout; ex_branch_taken_i pulsed during the wait has no effect; RUN resumes on ready.
4. mem_ready_i held low for MEM_TIMEOUT = 64 cycles → mem_timeout_o rises on cycle 64 and stays high after ready. reset_i pulse → state_o = 0 and mem_timeout_o = 0 asynchronously.
5. Branch taken in EX while ID holds a RAW-hazard instruction → if_id_flush = 1, id_ex_bubble = 1, issue_o = 0, no pend change.
6. WB retire of x3 with pend[x3] = 0 → sb_error_o = 1 and pend stays 0. Same-cycle issue and retire of x9 at pend = 1 → pend stays 1.
